// File: rtl/gost89_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gost89_pkg
// Brief    : Shared widths and S-box lookup helper for the GOST 28147-89
//            round datapath.
// Revision : 1.0 - initial release
// ============================================================================
package gost89_pkg;

    localparam int HALF_W  = 32;   // width of each Feistel half and of the key
    localparam int SBOX_W  = 512;  // 8 rows x 16 entries x 4 bits
    localparam int NIBBLES = 8;    // 4-bit groups per half
    localparam int ROT     = 11;   // left-rotate distance after substitution

    // Row r, entry v lives at bit offset 64*r + 4*v, which is exactly the
    // concatenation {row, nibble, 2'b00}.
    function automatic logic [3:0] sbox_lookup(
        input logic [SBOX_W-1:0] sbox,
        input logic [2:0]        row,
        input logic [3:0]        nibble
    );
        logic [8:0] base;
        base = {row, nibble, 2'b00};
        return sbox[base +: 4];
    endfunction

endpackage : gost89_pkg
`default_nettype wire

// File: rtl/gost89_sbox.sv
`default_nettype none
// ============================================================================
// Module   : gost89_sbox
// Brief    : Eight parallel 16:1 4-bit multiplexers; nibble r of din selects
//            an entry of S-box row r.
// Revision : 1.0 - initial release
// ============================================================================
module gost89_sbox
    import gost89_pkg::*;
(
    input  logic [SBOX_W-1:0] sbox,
    input  logic [HALF_W-1:0] din,
    output logic [HALF_W-1:0] dout
);

    // One independent table lookup per nibble position.
    for (genvar r = 0; r < NIBBLES; r++) begin : g_row
        assign dout[4*r +: 4] = sbox_lookup(sbox, 3'(r), din[4*r +: 4]);
    end

endmodule : gost89_sbox
`default_nettype wire

// File: rtl/gost89_round.sv
`default_nettype none
// ============================================================================
// Module   : gost89_round
// Brief    : One GOST 28147-89 Feistel round: key add mod 2^32, S-box
//            substitution, rotate-left-11, XOR with N2, half swap.
//            Combinational by default. Defining GOST89_ROUND_OUTREG_EN adds
//            an output register (1-cycle latency, async active-low clear).
// Revision : 1.0 - initial release
// ============================================================================
module gost89_round
    import gost89_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [SBOX_W-1:0] sbox,
    input  logic [HALF_W-1:0] key,
    input  logic [HALF_W-1:0] n1,
    input  logic [HALF_W-1:0] n2,
    output logic [HALF_W-1:0] out1,
    output logic [HALF_W-1:0] out2
);

    logic [HALF_W-1:0] w_sum;
    logic [HALF_W-1:0] w_subst;
    logic [HALF_W-1:0] w_rot;
    logic [HALF_W-1:0] w_out1;
    logic [HALF_W-1:0] w_out2;

    // Carry out of bit 31 is intentionally dropped (addition mod 2^32).
    assign w_sum = n1 + key;

    gost89_sbox u_sbox (
        .sbox (sbox),
        .din  (w_sum),
        .dout (w_subst)
    );

    // Rotate left by ROT: the top ROT bits wrap around to the bottom.
    assign w_rot  = {w_subst[HALF_W-ROT-1:0], w_subst[HALF_W-1:HALF_W-ROT]};
    assign w_out1 = w_rot ^ n2;
    assign w_out2 = n1;

`ifdef GOST89_ROUND_OUTREG_EN
    logic [HALF_W-1:0] r_out1;
    logic [HALF_W-1:0] r_out2;

    // Output register: sampled every edge, cleared immediately while reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out1 <= '0;
            r_out2 <= '0;
        end else begin
            r_out1 <= w_out1;
            r_out2 <= w_out2;
        end
    end

    assign out1 = r_out1;
    assign out2 = r_out2;
`else
    // Purely combinational build: clk and reset have no function here and
    // are only gathered into a sink so they do not appear as dangling inputs.
    logic w_unused_ports;
    assign w_unused_ports = &{1'b0, clk, reset};

    assign out1 = w_out1;
    assign out2 = w_out2;
`endif

endmodule : gost89_round
`default_nettype wire

// File: tb/tb_gost89_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_gost89_round
// Brief    : Self-checking bench for gost89_round: directed vector table,
//            per-row selectivity sweep, randomized vectors against a
//            behavioural model, and clock/reset corner sequences.
//            Works with and without GOST89_ROUND_OUTREG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gost89_round;

    localparam int C_RANDOM_VECTORS = 200;

    typedef struct {
        logic [511:0] sbox;
        logic [31:0]  key;
        logic [31:0]  n1;
        logic [31:0]  n2;
        logic [31:0]  exp1;
        logic [31:0]  exp2;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [511:0] sbox;
    logic [31:0]  key;
    logic [31:0]  n1;
    logic [31:0]  n2;
    logic [31:0]  out1;
    logic [31:0]  out2;

    int errors = 0;
    int checks = 0;

    gost89_round dut (
        .clk   (clk),
        .reset (reset),
        .sbox  (sbox),
        .key   (key),
        .n1    (n1),
        .n2    (n2),
        .out1  (out1),
        .out2  (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference round written straight from the algorithm description.
    function automatic void model(
        input  logic [511:0] tbl,
        input  logic [31:0]  k,
        input  logic [31:0]  a,
        input  logic [31:0]  b,
        output logic [31:0]  o1,
        output logic [31:0]  o2
    );
        logic [31:0] t;
        logic [31:0] s;
        int v;
        t = 32'((64'(a) + 64'(k)) % 64'h1_0000_0000);
        s = 32'h0;
        for (int r = 0; r < 8; r++) begin
            v = int'((t >> (4 * r)) & 32'hF);
            s = s | (32'((tbl >> (64 * r + 4 * v)) & 512'hF) << (4 * r));
        end
        o1 = ((s << 11) | (s >> 21)) ^ b;
        o2 = a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one vector and compare after the design's latency.
    task automatic apply(input vec_t v, input string name);
`ifdef GOST89_ROUND_OUTREG_EN
        @(negedge clk);
        sbox = v.sbox; key = v.key; n1 = v.n1; n2 = v.n2;
        @(posedge clk);
        #1;
`else
        sbox = v.sbox; key = v.key; n1 = v.n1; n2 = v.n2;
        #1;
`endif
        check({name, ".out1"}, out1, v.exp1);
        check({name, ".out2"}, out2, v.exp2);
    endtask

    function automatic logic [511:0] rand_sbox();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    vec_t         tbl [6];
    vec_t         v;
    logic [511:0] ident;

    initial begin
        ident = {8{64'hFEDCBA9876543210}};

        tbl[0] = '{512'h0,   32'h11111111, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h12345678};
        tbl[1] = '{ident,    32'h00000001, 32'h00000001, 32'h00000000, 32'h00001000, 32'h00000001};
        tbl[2] = '{ident,    32'h00000001, 32'hFFFFFFFF, 32'hCAFEBABE, 32'hCAFEBABE, 32'hFFFFFFFF};
        tbl[3] = '{ident,    32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFBFF, 32'h80000000};
        tbl[4] = '{{512{1'b1}}, 32'h00000000, 32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000};
        // Row 0 entry 3 = A; 0x0000000A rotated left by 11 is 0x00005000.
        tbl[5] = '{512'h0 | (512'hA << 12), 32'h0, 32'h3, 32'h0, 32'h00005000, 32'h00000003};

        reset = 1'b1;
        sbox = '0; key = '0; n1 = '0; n2 = '0;

`ifdef GOST89_ROUND_OUTREG_EN
        // Reset state: load something non-zero, then clear asynchronously.
        apply(tbl[0], "preload");
        #2;
        reset = 1'b0;
        #1;
        check("async_clear.out1", out1, 32'h0);
        check("async_clear.out2", out2, 32'h0);
        @(posedge clk); #1;
        check("held_clear.out1", out1, 32'h0);
        check("held_clear.out2", out2, 32'h0);
        // Release mid-cycle with a new vector: nothing moves until the edge.
        @(negedge clk);
        reset = 1'b1;
        sbox = tbl[1].sbox; key = tbl[1].key; n1 = tbl[1].n1; n2 = tbl[1].n2;
        #1;
        check("pre_edge.out1", out1, 32'h0);
        @(posedge clk); #1;
        check("first_edge.out1", out1, tbl[1].exp1);
        check("first_edge.out2", out2, tbl[1].exp2);
        // Latency: an input change right after an edge is invisible until the next.
        sbox = tbl[2].sbox; key = tbl[2].key; n1 = tbl[2].n1; n2 = tbl[2].n2;
        #2;
        check("latency_hold.out2", out2, tbl[1].exp2);
        @(posedge clk); #1;
        check("latency_next.out2", out2, tbl[2].exp2);
`else
        // Combinational: reset and clock have no effect on the outputs.
        sbox = tbl[0].sbox; key = tbl[0].key; n1 = tbl[0].n1; n2 = tbl[0].n2;
        #1;
        reset = 1'b0;
        #1;
        check("reset_ignored.out1", out1, tbl[0].exp1);
        check("reset_ignored.out2", out2, tbl[0].exp2);
        repeat (2) @(posedge clk);
        #1;
        check("clock_ignored.out1", out1, tbl[0].exp1);
        reset = 1'b1;
        // Input change with no clock edge: outputs follow at once.
        #2;
        n1 = 32'hDEADBEEF;
        #1;
        check("no_edge_follow.out2", out2, 32'hDEADBEEF);
`endif

        for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Row selectivity: a single marked entry in row r, reached only via nibble r.
        for (int r = 0; r < 8; r++) begin
            v.sbox = 512'hA << (64 * r + 12);
            v.key  = 32'h0;
            v.n1   = 32'h3 << (4 * r);
            v.n2   = 32'h0;
            model(v.sbox, v.key, v.n1, v.n2, v.exp1, v.exp2);
            apply(v, $sformatf("row%0d", r));
        end

        for (int i = 0; i < C_RANDOM_VECTORS; i++) begin
            v.sbox = rand_sbox();
            v.key  = $urandom;
            v.n1   = $urandom;
            v.n2   = $urandom;
            model(v.sbox, v.key, v.n1, v.n2, v.exp1, v.exp2);
            apply(v, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gost89_round
`default_nettype wire
